// File: rtl/stream_mux_n.sv
// stream_mux_n: parametrised N:1 stream multiplexer with a single registered
// output stage and valid/ready handshake on every port.
// Optional feature: define MUX_RR_EN to add the rr_mode port and a
// round-robin pointer; without it the mux is fixed-select only.
module stream_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
`ifdef MUX_RR_EN
  ,
  input  logic               rr_mode
`endif
);

  logic             can_load;
  logic             chan_ok;
  logic             chan_valid;
  logic             xfer;
  logic [SELW-1:0]  chan;
  logic [WIDTH-1:0] chan_data;

  assign can_load = !out_valid || out_ready;

`ifdef MUX_RR_EN
  // Pointer resets to the last channel so channel 0 wins first.
  localparam logic [SELW-1:0] PTR_RST = SELW'(N - 1);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_chan;
  int              rr_idx;
  logic            rr_found;

  // Round-robin search: first valid channel after ptr, wrapping modulo N.
  always_comb begin
    rr_chan  = SELW'((int'(ptr) + 1) % N);
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      rr_idx = (int'(ptr) + k) % N;
      if (!rr_found && in_valid[rr_idx]) begin
        rr_chan  = SELW'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  assign chan = rr_mode ? rr_chan : sel;

  // Pointer advances to the channel that actually transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_RST;
    end else if (xfer) begin
      ptr <= chan;
    end
  end
`else
  assign chan = sel;
`endif

  // Decode the chosen channel; a select beyond N-1 matches nothing.
  always_comb begin
    chan_ok    = 1'b0;
    chan_valid = 1'b0;
    chan_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == chan) begin
        chan_ok    = 1'b1;
        chan_valid = in_valid[i];
        chan_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only the chosen channel sees ready, and only when the output can take a word.
  // Ready is also held low while reset is asserted.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && can_load && chan_ok && (SELW'(i) == chan);
    end
  end

  assign xfer = can_load && chan_ok && chan_valid;

  // Output register: load on transfer, otherwise clear valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= chan_data;
      out_ch    <= chan;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
